// File: rtl/sdeser16_if.sv
// sdeser16_if: bundle between the serial receiver and its environment.
//   slave  modport : the receiver side (sdeser16).
//   master modport : the producer/consumer side (bit source and word sink).
// Signals:
//   i, i_valid        serial bit and its strobe
//   ssl               bit order for the next word (1 = MSB-first)
//   clear             synchronous abort of the partial word, clears overrun
//   res, res_valid,   holding register and its valid/ready handshake
//   res_ready
//   busy, count       partial word status
//   overrun           sticky "completed word dropped" flag
interface sdeser16_if #(
  parameter int WIDTH = 16
) ();
  localparam int CW = $clog2(WIDTH);

  logic             i;
  logic             i_valid;
  logic             ssl;
  logic             clear;
  logic [WIDTH-1:0] res;
  logic             res_valid;
  logic             res_ready;
  logic             busy;
  logic [CW-1:0]    count;
  logic             overrun;

  modport slave (
    input  i, i_valid, ssl, clear, res_ready,
    output res, res_valid, busy, count, overrun
  );

  modport master (
    output i, i_valid, ssl, clear, res_ready,
    input  res, res_valid, busy, count, overrun
  );
endinterface

// File: rtl/sdeser16.sv
// sdeser16: serial-to-parallel receiver, far end of a WIDTH-bit shift-out chain.
// Samples one bit per i_valid strobe, assembles WIDTH-bit words MSB- or
// LSB-first (order latched from ssl on the first bit of each word), and
// presents each completed word in a single holding register with a
// valid/ready handshake. A word completing while the holding register is
// still occupied is dropped and flags a sticky overrun.
// Ports:
//   clock  rising-edge system clock
//   reset  asynchronous active-low reset
//   bus    sdeser16_if.slave (serial input, control, word output, status)
module sdeser16 #(
  parameter int WIDTH = 16
) (
  input  logic       clock,
  input  logic       reset,
  sdeser16_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  // The bit counter is the state: zero means no partial word.
  typedef enum logic {S_IDLE, S_COLLECT} state_t;

  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_res;
  logic [CW-1:0]    r_count;
  logic             r_mode;
  logic             r_res_valid;
  logic             r_overrun;

  state_t           w_state;
  logic             w_order;
  logic             w_accept;
  logic             w_last;
  logic             w_take;
  logic             w_free;
  logic [WIDTH-1:0] w_sr_shift;
  logic [WIDTH-1:0] w_sr_nxt;
  logic [WIDTH-1:0] w_res_nxt;
  logic [CW-1:0]    w_count_nxt;
  logic             w_mode_nxt;
  logic             w_res_valid_nxt;
  logic             w_overrun_nxt;

  assign w_state  = (r_count == '0) ? S_IDLE : S_COLLECT;
  // ssl only matters on the first bit; later bits follow the latched order.
  assign w_order  = (w_state == S_IDLE) ? bus.ssl : r_mode;
  assign w_accept = bus.i_valid & ~bus.clear;
  assign w_last   = (r_count == CW'(WIDTH-1));
  assign w_take   = r_res_valid & bus.res_ready;
  // Holding register can take a new word if empty or being drained now.
  assign w_free   = ~r_res_valid | w_take;

  assign w_sr_shift = w_order ? {r_sr[WIDTH-2:0], bus.i}
                              : {bus.i, r_sr[WIDTH-1:1]};

  always_comb begin
    w_sr_nxt        = r_sr;
    w_res_nxt       = r_res;
    w_count_nxt     = r_count;
    w_mode_nxt      = r_mode;
    w_res_valid_nxt = r_res_valid;
    w_overrun_nxt   = r_overrun;

    // Output handshake runs regardless of clear.
    if (w_take) w_res_valid_nxt = 1'b0;

    if (bus.clear) begin
      w_sr_nxt      = '0;
      w_count_nxt   = '0;
      w_overrun_nxt = 1'b0;
    end else if (w_accept) begin
      w_sr_nxt = w_sr_shift;
      if (w_state == S_IDLE) w_mode_nxt = bus.ssl;
      if (w_last) begin
        // Explicit wrap keeps non-power-of-two WIDTH correct.
        w_count_nxt = '0;
        if (w_free) begin
          w_res_nxt       = w_sr_shift;
          w_res_valid_nxt = 1'b1;
        end else begin
          w_overrun_nxt = 1'b1;
        end
      end else begin
        w_count_nxt = r_count + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sr        <= '0;
      r_res       <= '0;
      r_count     <= '0;
      r_mode      <= 1'b0;
      r_res_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_sr        <= w_sr_nxt;
      r_res       <= w_res_nxt;
      r_count     <= w_count_nxt;
      r_mode      <= w_mode_nxt;
      r_res_valid <= w_res_valid_nxt;
      r_overrun   <= w_overrun_nxt;
    end
  end

  assign bus.res       = r_res;
  assign bus.res_valid = r_res_valid;
  assign bus.count     = r_count;
  assign bus.busy      = (r_count != '0);
  assign bus.overrun   = r_overrun;
endmodule

// File: tb/tb_sdeser16.sv
module tb_sdeser16;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  sdeser16_if #(.WIDTH(16)) bus ();

  sdeser16 #(.WIDTH(16)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are changed and outputs sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send the first n bits of w in the given order, one per cycle.
  task automatic send_bits(input logic [15:0] w, input logic msb, input int n);
    for (int k = 0; k < n; k++) begin
      bus.i       = msb ? w[15-k] : w[k];
      bus.i_valid = 1'b1;
      tick();
    end
    bus.i_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (bus.res !== 16'h0)    begin errors++; $display("FAIL reset_res got %h exp 0000", bus.res); end
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.res_valid); end
    checks++; if (bus.count !== 4'd0)   begin errors++; $display("FAIL reset_count got %0d exp 0", bus.count); end
    checks++; if (bus.busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", bus.overrun); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_msb_basic();
    logic [15:0] w;
    w = 16'hA5C3;
    bus.ssl = 1'b1;
    bus.res_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      bus.i = w[15-k];
      bus.i_valid = 1'b1;
      tick();
      checks++; if (bus.count !== 4'((k+1) % 16)) begin errors++; $display("FAIL msb_count bit %0d got %0d exp %0d", k, bus.count, (k+1) % 16); end
      checks++; if (bus.busy !== (k != 15)) begin errors++; $display("FAIL msb_busy bit %0d got %b exp %b", k, bus.busy, (k != 15)); end
      checks++; if (bus.res_valid !== (k == 15)) begin errors++; $display("FAIL msb_valid bit %0d got %b exp %b", k, bus.res_valid, (k == 15)); end
    end
    bus.i_valid = 1'b0;
    checks++; if (bus.res !== 16'hA5C3) begin errors++; $display("FAIL msb_res got %h exp a5c3", bus.res); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL msb_overrun got %b exp 0", bus.overrun); end
    tick();
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL msb_valid_drop got %b exp 0", bus.res_valid); end
  endtask

  task automatic test_lsb_gaps();
    logic [15:0] w;
    w = 16'h1234;
    bus.ssl = 1'b0;
    bus.res_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      for (int g = 0; g < (k % 4); g++) begin
        bus.i_valid = 1'b0;
        bus.ssl = ~bus.ssl;
        tick();
      end
      if (k > 0) bus.ssl = k[0];
      bus.i = w[k];
      bus.i_valid = 1'b1;
      tick();
    end
    bus.i_valid = 1'b0;
    checks++; if (bus.res !== 16'h1234) begin errors++; $display("FAIL lsb_res got %h exp 1234", bus.res); end
    checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL lsb_valid got %b exp 1", bus.res_valid); end
    tick();
  endtask

  task automatic test_backpressure();
    bus.res_ready = 1'b0;
    send_bits(16'h00FF, 1'b1, 16);
    checks++; if (bus.res !== 16'h00FF || bus.res_valid !== 1'b1) begin errors++; $display("FAIL bp_first got %h/%b exp 00ff/1", bus.res, bus.res_valid); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL bp_no_ovr got %b exp 0", bus.overrun); end
    send_bits(16'hFF00, 1'b1, 16);
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL bp_ovr got %b exp 1", bus.overrun); end
    checks++; if (bus.res !== 16'h00FF || bus.res_valid !== 1'b1) begin errors++; $display("FAIL bp_hold got %h/%b exp 00ff/1", bus.res, bus.res_valid); end
    bus.res_ready = 1'b1;
    tick();
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", bus.res_valid); end
    checks++; if (bus.res !== 16'h00FF) begin errors++; $display("FAIL bp_res_keep got %h exp 00ff", bus.res); end
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL bp_ovr_sticky got %b exp 1", bus.overrun); end
  endtask

  task automatic test_simultaneous();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL sim_clear_ovr got %b exp 0", bus.overrun); end
    bus.res_ready = 1'b0;
    send_bits(16'hBEEF, 1'b1, 16);
    checks++; if (bus.res !== 16'hBEEF || bus.res_valid !== 1'b1) begin errors++; $display("FAIL sim_beef got %h/%b exp beef/1", bus.res, bus.res_valid); end
    send_bits(16'hCAFE, 1'b1, 15);
    checks++; if (bus.res !== 16'hBEEF) begin errors++; $display("FAIL sim_beef_hold got %h exp beef", bus.res); end
    bus.i = 1'b0;           // bit 0 of 0xCAFE, last in MSB order
    bus.i_valid = 1'b1;
    bus.res_ready = 1'b1;
    tick();
    bus.i_valid = 1'b0;
    bus.res_ready = 1'b0;
    checks++; if (bus.res !== 16'hCAFE) begin errors++; $display("FAIL sim_res got %h exp cafe", bus.res); end
    checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL sim_valid got %b exp 1", bus.res_valid); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL sim_ovr got %b exp 0", bus.overrun); end
    bus.res_ready = 1'b1;
    tick();
  endtask

  task automatic test_clear();
    bus.res_ready = 1'b0;
    send_bits(16'h0F0F, 1'b1, 16);
    send_bits(16'hF0F0, 1'b1, 16);
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL clr_pre_ovr got %b exp 1", bus.overrun); end
    send_bits(16'h1111, 1'b1, 7);
    checks++; if (bus.count !== 4'd7) begin errors++; $display("FAIL clr_pre_count got %0d exp 7", bus.count); end
    bus.clear = 1'b1;
    bus.i = 1'b1;
    bus.i_valid = 1'b1;
    tick();
    bus.clear = 1'b0;
    bus.i_valid = 1'b0;
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL clr_count got %0d exp 0", bus.count); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL clr_busy got %b exp 0", bus.busy); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL clr_ovr got %b exp 0", bus.overrun); end
    checks++; if (bus.res !== 16'h0F0F || bus.res_valid !== 1'b1) begin errors++; $display("FAIL clr_res_keep got %h/%b exp 0f0f/1", bus.res, bus.res_valid); end
    bus.res_ready = 1'b1;
    send_bits(16'h5A5A, 1'b1, 16);
    checks++; if (bus.res !== 16'h5A5A || bus.res_valid !== 1'b1) begin errors++; $display("FAIL clr_after got %h/%b exp 5a5a/1", bus.res, bus.res_valid); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL clr_after_ovr got %b exp 0", bus.overrun); end
    tick();
  endtask

  task automatic test_async_reset();
    bus.res_ready = 1'b0;
    send_bits(16'h3C3C, 1'b1, 16);
    send_bits(16'hFFFF, 1'b1, 9);
    checks++; if (bus.count !== 4'd9 || bus.res_valid !== 1'b1) begin errors++; $display("FAIL ar_pre got %0d/%b exp 9/1", bus.count, bus.res_valid); end
    #2;
    rst_n = 1'b0;          // mid-cycle, no clock edge until reset is checked
    #1;
    checks++; if (bus.res !== 16'h0 || bus.res_valid !== 1'b0) begin errors++; $display("FAIL ar_res got %h/%b exp 0000/0", bus.res, bus.res_valid); end
    checks++; if (bus.count !== 4'd0 || bus.busy !== 1'b0) begin errors++; $display("FAIL ar_count got %0d/%b exp 0/0", bus.count, bus.busy); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ar_ovr got %b exp 0", bus.overrun); end
    #2;
    rst_n = 1'b1;
    tick();
    bus.res_ready = 1'b1;
    send_bits(16'h8001, 1'b1, 16);
    checks++; if (bus.res !== 16'h8001 || bus.res_valid !== 1'b1) begin errors++; $display("FAIL ar_after got %h/%b exp 8001/1", bus.res, bus.res_valid); end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL ar_after_count got %0d exp 0", bus.count); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.i = 1'b0;
    bus.i_valid = 1'b0;
    bus.ssl = 1'b1;
    bus.clear = 1'b0;
    bus.res_ready = 1'b0;
    test_reset();
    test_msb_basic();
    test_lsb_gaps();
    test_backpressure();
    test_simultaneous();
    test_clear();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
